// File: rtl/myproject_mac_pipe.sv
// Pipelined multiply-accumulate producing one signed dot product per in_last term.
// Define MYPROJECT_MAC_SAT_EN to clamp dout to its signed range and flag overflow.
module myproject_mac_pipe #(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 10,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int DOUT_WIDTH  = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  overflow
);

  // An unsigned din1 needs one extra bit so the product stays exact.
  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + ((DIN1_SIGNED != 0) ? 0 : 1);

  logic signed [PROD_WIDTH-1:0] din0_ext_s;
  logic signed [PROD_WIDTH-1:0] din1_ext_s;
  logic signed [PROD_WIDTH-1:0] prod_s;
  logic signed [PROD_WIDTH-1:0] prod_r [NUM_STAGE];
  logic [NUM_STAGE-1:0]         vld_r;
  logic [NUM_STAGE-1:0]         last_r;

  logic                         term_vld_s;
  logic                         term_last_s;
  logic signed [ACC_WIDTH-1:0]  prod_ext_s;
  logic signed [ACC_WIDTH-1:0]  acc_sum_s;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic                         first_r;
  logic [DOUT_WIDTH-1:0]        dout_nxt_s;
  logic                         ovf_nxt_s;

  assign din0_ext_s = PROD_WIDTH'($signed(din0));

  generate
    if (DIN1_SIGNED != 0) begin : g_din1_signed
      assign din1_ext_s = PROD_WIDTH'($signed(din1));
    end else begin : g_din1_unsigned
      assign din1_ext_s = PROD_WIDTH'({1'b0, din1});
    end
  endgenerate

  assign prod_s = din0_ext_s * din1_ext_s;

  // Product pipeline with valid/last shadow flags moving in lockstep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_r[i] <= '0;
      end
      vld_r  <= '0;
      last_r <= '0;
    end else if (ce) begin
      prod_r[0] <= prod_s;
      vld_r[0]  <= in_valid;
      last_r[0] <= in_valid & in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_r[i] <= prod_r[i-1];
        vld_r[i]  <= vld_r[i-1];
        last_r[i] <= last_r[i-1];
      end
    end
  end

  assign term_vld_s  = vld_r[NUM_STAGE-1];
  assign term_last_s = last_r[NUM_STAGE-1];
  assign prod_ext_s  = ACC_WIDTH'(prod_r[NUM_STAGE-1]);

  // Next accumulator value: the first term of a vector loads instead of adding.
  always_comb begin
    acc_sum_s = acc_r;
    if (first_r) begin
      acc_sum_s = prod_ext_s;
    end else begin
      acc_sum_s = acc_r + prod_ext_s;
    end
  end

`ifdef MYPROJECT_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] DOUT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DOUT_MIN = ~DOUT_MAX;

  // Clamp the final sum into the signed dout range.
  always_comb begin
    dout_nxt_s = acc_sum_s[DOUT_WIDTH-1:0];
    ovf_nxt_s  = 1'b0;
    if (acc_sum_s > DOUT_MAX) begin
      dout_nxt_s = DOUT_MAX[DOUT_WIDTH-1:0];
      ovf_nxt_s  = 1'b1;
    end else if (acc_sum_s < DOUT_MIN) begin
      dout_nxt_s = DOUT_MIN[DOUT_WIDTH-1:0];
      ovf_nxt_s  = 1'b1;
    end else begin
      dout_nxt_s = acc_sum_s[DOUT_WIDTH-1:0];
      ovf_nxt_s  = 1'b0;
    end
  end
`else
  // Wrapping result: low bits of the final sum, never flagged.
  always_comb begin
    dout_nxt_s = acc_sum_s[DOUT_WIDTH-1:0];
    ovf_nxt_s  = 1'b0;
  end
`endif

  // Accumulator, first-term flag and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r     <= '0;
      first_r   <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
      overflow  <= 1'b0;
    end else if (ce) begin
      out_valid <= term_vld_s & term_last_s;
      if (term_vld_s) begin
        acc_r   <= acc_sum_s;
        first_r <= term_last_s;
        if (term_last_s) begin
          dout     <= dout_nxt_s;
          overflow <= ovf_nxt_s;
        end
      end
    end
  end

endmodule
